vga_rx_timing: RTL and testbench

Receive-side counterpart of the VGA pattern generator. Samples an incoming 640x480@60 stream (h_sync, v_sync, 1-bit R/G/B) on the pixel clock enable, recovers pixel coordinates from sync edges, checks line and frame timing against nominal values, and declares lock. Sits in front of capture and self-check logic, and serves as a loopback monitor for the on-board generator.

---
 rtl/vga_rx_timing_if.sv | 32 +++
 rtl/vga_rx_timing.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_rx_timing.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx_timing_if.sv
// Video-in and recovered-pixel bundle for vga_rx_timing.
// master = video source side, slave = the receiver.
interface vga_rx_timing_if;
    logic       pix_ce;
    logic       h_sync_in;
    logic       v_sync_in;
    logic       r_in;
    logic       g_in;
    logic       b_in;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       pix_valid;
    logic       r_out;
    logic       g_out;
    logic       b_out;
    logic       frame_start;
    logic       locked;
    logic       line_err;
    logic       frame_err;

    modport master (
        output pix_ce, h_sync_in, v_sync_in, r_in, g_in, b_in,
        input  pix_x, pix_y, pix_valid, r_out, g_out, b_out, frame_start, locked,
               line_err, frame_err
    );

    modport slave (
        input  pix_ce, h_sync_in, v_sync_in, r_in, g_in, b_in,
        output pix_x, pix_y, pix_valid, r_out, g_out, b_out, frame_start, locked,
               line_err, frame_err
    );
endinterface

// File: rtl/vga_rx_timing.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates from sync edges, checks line and
// frame periods and declares lock. Define VGA_RX_ERR_CNT_EN to add the o_err_count output.
module vga_rx_timing #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst,
    vga_rx_timing_if.slave io_vga
`ifdef VGA_RX_ERR_CNT_EN
    ,
    output logic [7:0]     o_err_count
`endif
);
    localparam logic [9:0]  H_FIRST     = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_LAST      = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST     = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_LAST      = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_PERIOD    = 11'(H_TOTAL);
    localparam logic [10:0] V_PERIOD    = 11'(V_TOTAL);
    localparam int unsigned TIMEOUT_RAW = 2 * H_TOTAL - 1;
    // The counter saturates at 1023, so a larger timeout would never be reached.
    localparam logic [9:0]  H_TIMEOUT   = (TIMEOUT_RAW > 1023) ? 10'd1023 : 10'(TIMEOUT_RAW);
    localparam logic [2:0]  LOCK_N      = 3'(LOCK_FRAMES);
    localparam logic [9:0]  CNT_MAX     = 10'h3ff;

    typedef enum logic {StUnlocked, StLocked} state_e;

    logic       r_h_prev;
    logic       r_v_prev;
    logic       r_arm;
    logic       r_h_seen;
    logic       r_v_seen;
    logic       r_frame_bad;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    state_e     r_state;
    logic [2:0] r_good_cnt;
    logic [9:0] r_pix_x;
    logic [8:0] r_pix_y;
    logic       r_pix_valid;
    logic       r_red;
    logic       r_grn;
    logic       r_blu;
    logic       r_frame_start;
    logic       r_locked;
    logic       r_line_err;
    logic       r_frame_err;

    logic       w_h_fall;
    logic       w_v_fall;
    logic       w_armed_edge;
    logic       w_line_bad;
    logic       w_timeout;
    logic       w_line_err;
    logic       w_frame_chk;
    logic       w_frame_good;
    logic       w_frame_err;
    logic       w_active;
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic [9:0] w_x;
    logic [8:0] w_y;

    always_comb begin
        w_h_fall     = r_h_prev & ~io_vga.h_sync_in;
        w_v_fall     = r_v_prev & ~io_vga.v_sync_in;
        // A pending v edge is consumed by this or any later h edge.
        w_armed_edge = w_h_fall & (r_arm | w_v_fall);

        if (w_h_fall) begin
            w_h_nxt = '0;
        end else if (r_h_cnt == CNT_MAX) begin
            w_h_nxt = r_h_cnt;
        end else begin
            w_h_nxt = r_h_cnt + 10'd1;
        end

        if (w_armed_edge) begin
            w_v_nxt = '0;
        end else if (w_h_fall && (r_v_cnt != CNT_MAX)) begin
            w_v_nxt = r_v_cnt + 10'd1;
        end else begin
            w_v_nxt = r_v_cnt;
        end

        w_line_bad   = w_h_fall & r_h_seen & (({1'b0, r_h_cnt} + 11'd1) != H_PERIOD);
        w_timeout    = ~w_h_fall & (r_h_cnt != H_TIMEOUT) & (w_h_nxt == H_TIMEOUT);
        w_line_err   = w_line_bad | w_timeout;

        // The line closed by the armed edge still belongs to the frame being judged.
        w_frame_chk  = w_armed_edge & r_v_seen;
        w_frame_good = (({1'b0, r_v_cnt} + 11'd1) == V_PERIOD) & ~r_frame_bad & ~w_line_err;
        w_frame_err  = w_frame_chk & ~w_frame_good;

        w_active     = (w_h_nxt >= H_FIRST) & (w_h_nxt <= H_LAST) &
                       (w_v_nxt >= V_FIRST) & (w_v_nxt <= V_LAST);
        w_x          = w_h_nxt - H_FIRST;
        w_y          = 9'(w_v_nxt - V_FIRST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_prev    <= 1'b1;
            r_v_prev    <= 1'b1;
            r_arm       <= 1'b0;
            r_h_seen    <= 1'b0;
            r_v_seen    <= 1'b0;
            r_frame_bad <= 1'b0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
        end else if (io_vga.pix_ce) begin
            r_h_prev <= io_vga.h_sync_in;
            r_v_prev <= io_vga.v_sync_in;
            r_h_cnt  <= w_h_nxt;
            r_v_cnt  <= w_v_nxt;
            if (w_h_fall) begin
                r_h_seen <= 1'b1;
            end
            if (w_armed_edge) begin
                r_arm       <= 1'b0;
                r_v_seen    <= 1'b1;
                r_frame_bad <= 1'b0;
            end else begin
                if (w_v_fall) begin
                    r_arm <= 1'b1;
                end
                if (w_line_err) begin
                    r_frame_bad <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StUnlocked;
            r_good_cnt    <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_valid   <= 1'b0;
            r_red         <= 1'b0;
            r_grn         <= 1'b0;
            r_blu         <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            // Pulses last exactly one clk, independent of pix_ce.
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            if (io_vga.pix_ce) begin
                r_line_err  <= w_line_err;
                r_frame_err <= w_frame_err;
                if (w_active && (r_state == StLocked)) begin
                    r_pix_valid   <= 1'b1;
                    r_pix_x       <= w_x;
                    r_pix_y       <= w_y;
                    r_red         <= io_vga.r_in;
                    r_grn         <= io_vga.g_in;
                    r_blu         <= io_vga.b_in;
                    r_frame_start <= (w_h_nxt == H_FIRST) && (w_v_nxt == V_FIRST);
                end
                unique case (r_state)
                    StUnlocked: begin
                        if (w_frame_chk) begin
                            if (!w_frame_good) begin
                                r_good_cnt <= '0;
                            end else if ((r_good_cnt + 3'd1) == LOCK_N) begin
                                r_state    <= StLocked;
                                r_locked   <= 1'b1;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= r_good_cnt + 3'd1;
                            end
                        end
                    end
                    StLocked: begin
                        if (w_line_err || w_frame_err) begin
                            r_state    <= StUnlocked;
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign io_vga.pix_x       = r_pix_x;
    assign io_vga.pix_y       = r_pix_y;
    assign io_vga.pix_valid   = r_pix_valid;
    assign io_vga.r_out       = r_red;
    assign io_vga.g_out       = r_grn;
    assign io_vga.b_out       = r_blu;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.locked      = r_locked;
    assign io_vga.line_err    = r_line_err;
    assign io_vga.frame_err   = r_frame_err;

`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] r_err_count;
    logic [8:0] w_err_sum;

    // Both pulses in one clk count as two.
    always_comb begin
        w_err_sum = {1'b0, r_err_count} + {8'd0, r_line_err} + {8'd0, r_frame_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_err_sum[8]) begin
            r_err_count <= 8'hff;
        end else begin
            r_err_count <= w_err_sum[7:0];
        end
    end

    assign o_err_count = r_err_count;
`endif
endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing on a scaled-down raster (16x12 total, 8x6 active) so full frames stay
// short; a generator drives sync/colour and queues the pixels the receiver must deliver.
module tb_vga_rx_timing;
    localparam int HA  = 8;
    localparam int HS  = 2;
    localparam int HB  = 2;
    localparam int HT  = 16;
    localparam int VA  = 6;
    localparam int VS  = 1;
    localparam int VB  = 2;
    localparam int VT  = 12;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       r;
        logic       g;
        logic       b;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rx_timing_if vga ();
`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    vga_rx_timing #(
        .H_ACTIVE    (HA),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .H_TOTAL     (HT),
        .V_ACTIVE    (VA),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .V_TOTAL     (VT),
        .LOCK_FRAMES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_vga (vga)
`ifdef VGA_RX_ERR_CNT_EN
        ,
        .o_err_count (err_count)
`endif
    );

    pix_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   exp_lock = 1'b0;
    int   exp_err_total = 0;
    int   n_valid, n_fs, n_red, n_line_err, n_frame_err;
    logic lock_at_line_err, lock_at_frame_err;
    logic lock_before, lock_after, lock_line_start;

    task automatic send_sample(input logic hs, input logic vs, input logic r, input logic g,
                               input logic b, input bit push, input pix_t e);
        pix_t got;
        pix_t want;
        @(negedge clk);
        n_checks++;
        if ({vga.pix_valid, vga.frame_start, vga.line_err, vga.frame_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL pulse_clear: got %b want 0000",
                     {vga.pix_valid, vga.frame_start, vga.line_err, vga.frame_err});
        end
        vga.h_sync_in = hs;
        vga.v_sync_in = vs;
        vga.r_in      = r;
        vga.g_in      = g;
        vga.b_in      = b;
        vga.pix_ce    = 1'b1;
        if (push) sb.push_back(e);
        @(negedge clk);
        vga.pix_ce = 1'b0;
        if (vga.line_err) begin
            n_line_err++;
            lock_at_line_err = vga.locked;
        end
        if (vga.frame_err) begin
            n_frame_err++;
            lock_at_frame_err = vga.locked;
        end
        if (vga.frame_start) n_fs++;
        if (vga.pix_valid) begin
            n_valid++;
            if (vga.r_out) n_red++;
            got = '{x: vga.pix_x, y: vga.pix_y, r: vga.r_out, g: vga.g_out, b: vga.b_out,
                    fs: vga.frame_start};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pix_valid: got x=%0d y=%0d want no pulse",
                         got.x, got.y);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL pixel: got x=%0d y=%0d rgb=%b%b%b fs=%b want x=%0d y=%0d rgb=%b%b%b fs=%b",
                             got.x, got.y, got.r, got.g, got.b, got.fs,
                             want.x, want.y, want.r, want.g, want.b, want.fs);
                end
            end
        end
    endtask

    task automatic send_line(input int v, input int len);
        for (int h = 0; h < len; h++) begin
            int   x;
            int   y;
            bit   act;
            logic r, g, b;
            pix_t e;
            x   = h - HST;
            y   = v - VST;
            act = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
            r   = act && (x >= 2) && (x <= 4) && (y >= 1) && (y <= 3);
            g   = act && (((x + y) % 2) == 1);
            b   = act && (x >= 4);
            e   = '{x: 10'(x), y: 9'(y), r: r, g: g, b: b, fs: (x == 0) && (y == 0)};
            send_sample((h >= HS) ? 1'b1 : 1'b0, (v >= VS) ? 1'b1 : 1'b0, r, g, b,
                        act && exp_lock, e);
            if (h == 0) lock_line_start = vga.locked;
        end
    endtask

    task automatic send_frame(input int lines, input int short_line);
        lock_before = vga.locked;
        for (int v = 0; v < lines; v++) begin
            if (short_line >= 0 && v == short_line + 1) exp_lock = 1'b0;
            send_line(v, (v == short_line) ? HT - 1 : HT);
            if (v == 0) lock_after = lock_line_start;
        end
    endtask

    task automatic clear_counts();
        n_valid = 0; n_fs = 0; n_red = 0; n_line_err = 0; n_frame_err = 0;
    endtask

    task automatic test_reset();
        vga.pix_ce = 1'b0; vga.h_sync_in = 1'b1; vga.v_sync_in = 1'b1;
        vga.r_in = 1'b0; vga.g_in = 1'b0; vga.b_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({vga.pix_valid, vga.frame_start, vga.locked, vga.line_err, vga.frame_err,
             vga.r_out, vga.g_out, vga.b_out, vga.pix_x, vga.pix_y} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b fs=%b lock=%b x=%0d y=%0d want all 0",
                     vga.pix_valid, vga.frame_start, vga.locked, vga.pix_x, vga.pix_y);
        end
`ifdef VGA_RX_ERR_CNT_EN
        n_checks++;
        if (err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        clear_counts();
        exp_lock = 1'b0;
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b0) begin
            n_errors++; $display("FAIL lock_frame1: got %b want 0", lock_after);
        end
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b0) begin
            n_errors++; $display("FAIL lock_frame2: got %b want 0", lock_after);
        end
        exp_lock = 1'b1;
        send_frame(VT, -1);
        n_checks++;
        if ({lock_before, lock_after} !== 2'b01) begin
            n_errors++;
            $display("FAIL lock_rise: got before=%b after=%b want 0 then 1", lock_before, lock_after);
        end
        n_checks++;
        if (n_line_err != 0 || n_frame_err != 0) begin
            n_errors++;
            $display("FAIL lock_no_errors: got line=%0d frame=%0d want 0 0", n_line_err, n_frame_err);
        end
    endtask

    task automatic test_pixels();
        clear_counts();
        send_frame(VT, -1);
        n_checks++;
        if (n_valid != HA * VA) begin
            n_errors++; $display("FAIL valid_count: got %0d want %0d", n_valid, HA * VA);
        end
        n_checks++;
        if (n_fs != 1) begin
            n_errors++; $display("FAIL frame_start_count: got %0d want 1", n_fs);
        end
        n_checks++;
        if (n_red != 9) begin
            n_errors++; $display("FAIL red_count: got %0d want 9", n_red);
        end
        n_checks++;
        if (sb.size() != 0 || vga.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL pixels_drained: got pending=%0d locked=%b want 0 1", sb.size(), vga.locked);
        end
    endtask

    task automatic test_short_line();
        clear_counts();
        send_frame(VT, 3);
        n_checks++;
        if (n_line_err != 1 || lock_at_line_err !== 1'b0 || n_frame_err != 0) begin
            n_errors++;
            $display("FAIL short_line_err: got line=%0d lock=%b frame=%0d want 1 0 0",
                     n_line_err, lock_at_line_err, n_frame_err);
        end
        send_frame(VT, -1);
        n_checks++;
        if (n_frame_err != 1 || lock_at_frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL short_line_frame_err: got frame=%0d lock=%b want 1 0",
                     n_frame_err, lock_at_frame_err);
        end
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b0) begin
            n_errors++; $display("FAIL relock_early: got %b want 0", lock_after);
        end
        exp_lock = 1'b1;
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b1 || n_line_err != 1 || n_frame_err != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL relock: got lock=%b line=%0d frame=%0d pending=%0d want 1 1 1 0",
                     lock_after, n_line_err, n_frame_err, sb.size());
        end
        exp_err_total += 2;
    endtask

    task automatic test_short_frame();
        clear_counts();
        send_frame(VT - 1, -1);
        exp_lock = 1'b0;
        send_frame(VT, -1);
        n_checks++;
        if (n_frame_err != 1 || n_line_err != 0 || lock_at_frame_err !== 1'b0 ||
            lock_before !== 1'b1 || lock_after !== 1'b0) begin
            n_errors++;
            $display("FAIL short_frame: got frame=%0d line=%0d lock_err=%b before=%b after=%b want 1 0 0 1 0",
                     n_frame_err, n_line_err, lock_at_frame_err, lock_before, lock_after);
        end
        exp_err_total += 1;
`ifdef VGA_RX_ERR_CNT_EN
        n_checks++;
        if (err_count !== 8'(exp_err_total)) begin
            n_errors++; $display("FAIL err_count: got %0d want %0d", err_count, exp_err_total);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        send_frame(VT, -1);
        exp_lock = 1'b1;
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset_lock: got %b want 1", lock_after);
        end
        clear_counts();
        for (int v = 0; v < 5; v++) send_line(v, HT);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({vga.pix_valid, vga.frame_start, vga.locked, vga.line_err, vga.frame_err,
             vga.r_out, vga.g_out, vga.b_out, vga.pix_x, vga.pix_y} !== '0) begin
            n_errors++;
            $display("FAIL midframe_reset: got lock=%b x=%0d y=%0d rgb=%b%b%b want all 0",
                     vga.locked, vga.pix_x, vga.pix_y, vga.r_out, vga.g_out, vga.b_out);
        end
        rst = 1'b0;
        exp_lock = 1'b0;
        exp_err_total = 0;
        for (int v = 5; v < VT; v++) send_line(v, HT);
        send_frame(VT, -1);
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b0) begin
            n_errors++; $display("FAIL reset_relock_early: got %b want 0", lock_after);
        end
        exp_lock = 1'b1;
        send_frame(VT, -1);
        n_checks++;
        if (lock_after !== 1'b1 || n_line_err != 0 || n_frame_err != 0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL reset_relock: got lock=%b line=%0d frame=%0d pending=%0d want 1 0 0 0",
                     lock_after, n_line_err, n_frame_err, sb.size());
        end
`ifdef VGA_RX_ERR_CNT_EN
        n_checks++;
        if (err_count !== 8'(exp_err_total)) begin
            n_errors++; $display("FAIL err_count_after_reset: got %0d want 0", err_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_short_frame();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
